wb_timer: RTL and testbench
===========================

// Module: wb_timer
// PURPOSE
//  RISC-V machine timer: Wishbone slave holding a 64-bit mtime counter and a 64-bit mtimecmp.
//  Sits on one slave port of the shared-bus interconnect, next to the LED and RAM slaves.
//  Produces the timer interrupt that drives the core's irq_timer input.
//  Includes a programmable prescaler so mtime can tick slower than clk.
// PARAMETERS
//  ADDR_W   5        byte-address bits decoded (register window 32 B; upper bits ignored)
//  PRESC_W  16       width of the prescale divisor field
// PORTS
//  clk       in   1        system clock
//  rst_n     in   1        asynchronous active-low reset
//  wb_cyc    in   1        Wishbone cycle
//  wb_stb    in   1        Wishbone strobe (pipelined Wishbone)
//  wb_we     in   1        1 = write, 0 = read
//  wb_adr    in   ADDR_W   byte address, bits [1:0] ignored
//  wb_sel    in   4        byte enables for writes
//  wb_dat_i  in   32       write data
//  wb_dat_o  out  32       read data, valid while wb_ack = 1
//  wb_ack    out  1        single-cycle acknowledge
//  wb_stall  out  1        constant 0
//  wb_err    out  1        constant 0
//  irq_timer out  1        level interrupt to core
// BEHAVIOUR
//  Register map (offset):
//   0x00 MTIME_LO    RW
//   0x04 MTIME_HI    RW
//   0x08 MTIMECMP_LO RW
//   0x0C MTIMECMP_HI RW
//   0x10 CTRL        RW: [0] EN; [PRESC_W+7:8] PRESC
//   Other offsets: reads 0, writes ignored, still acked.
//  Reset values:
//   mtime 0, mtimecmp 64'hFFFF_FFFF_FFFF_FFFF, CTRL 0, prescale count 0
//   wb_ack 0, wb_dat_o 0, irq_timer 0
//  Handshake:
//   - A request is accepted every cycle with cyc & stb; wb_stall is always 0.
//   - wb_ack is registered: it is 1 exactly one cycle after acceptance, for 1 cycle.
//   - Back-to-back requests give back-to-back acks.
//   - wb_dat_o is registered with the ack and holds the value read in the accept cycle.
//   - wb_dat_o is 0 when ack = 0.
//  Writes:
//   - Byte-granular per wb_sel; take effect at the clock edge of acceptance.
//   - A write to CTRL also clears the prescale count to 0.
//  Tick:
//   - While EN = 1, the prescale count increments every cycle.
//   - When it equals PRESC: count <= 0 and mtime <= mtime + 1.
//   - PRESC = 0 gives one increment per clk.
//   - While EN = 0, mtime and the count hold.
//  Arithmetic: full 64-bit increment, carry from LO into HI in the same cycle; 2^64-1 wraps to 0.
//  Collision: a bus write to MTIME_LO/HI in a tick cycle wins for the written bytes.
//   - Unwritten bytes take the incremented value.
//   - Implement as next = mtime + tick, then byte-overlay.
//  Interrupt: irq_timer <= (mtime >= mtimecmp), unsigned 64-bit compare, registered.
//   - It lags by 1 cycle and is independent of EN.
//   - It clears 1 cycle after software raises mtimecmp above mtime.
//  Reset mid-transfer: a pending ack is dropped, and all registers return to reset values immediately.
// TESTING
//  T1 Reset, then read 0x00, 0x04, 0x08, 0x10
//     -> 0, 0, 0xFFFFFFFF, 0; each ack exactly 1 cycle after stb; irq_timer = 0.
//  T2 Write CTRL = 0x0000_0301 (EN = 1, PRESC = 3); wait 40 cycles
//     -> mtime advances 1 per 4 clk (10 ± 1); CTRL read-back is 0x301.
//  T3 Write MTIME_LO = 0xFFFF_FFFE, MTIME_HI = 0, PRESC = 0, EN = 1
//     -> after 2 ticks MTIME_HI = 1, MTIME_LO = 0.
//     Also load 2^64-1 -> next tick reads 0/0.
//  T4 Write MTIMECMP = 100 with mtime counting from 0, PRESC = 0
//     -> irq_timer rises the cycle after mtime reaches 100.
//     Then write MTIMECMP_HI = 1 -> irq_timer falls 1 cycle later.
//  T5 Write MTIME_LO with wb_sel = 4'b0001, data 0xAA, in a tick cycle
//     -> byte 0 = 0xAA; bytes 3:1 equal the incremented value.
//  T6 Back-to-back 4 reads and an unmapped offset 0x1C
//     -> 4 consecutive acks with correct data; 0x1C reads 0.
//     Also: assert rst_n mid-transfer -> no ack.

Source files
------------

// File: rtl/wb_timer.sv
// RISC-V machine timer on a pipelined Wishbone slave port: 64-bit mtime/mtimecmp,
// prescaled tick, and a registered level interrupt (mtime >= mtimecmp).
module wb_timer #(
    parameter int ADDR_W  = 5,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [3:0]        wb_sel,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack,
    output logic              wb_stall,
    output logic              wb_err,
    output logic              irq_timer
);
    localparam logic [2:0] REG_MTIME_LO = 3'd0;
    localparam logic [2:0] REG_MTIME_HI = 3'd1;
    localparam logic [2:0] REG_CMP_LO   = 3'd2;
    localparam logic [2:0] REG_CMP_HI   = 3'd3;
    localparam logic [2:0] REG_CTRL     = 3'd4;

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic               en;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;

    logic               accept;
    logic               wr;
    logic               tick;
    logic [2:0]         word;
    logic [31:0]        bmask;
    logic [31:0]        ctrl_val;
    logic [31:0]        ctrl_new;
    logic [31:0]        rdata;
    logic [63:0]        mtime_inc;
    logic [63:0]        mtime_next;
    logic [63:0]        cmp_next;
    logic               unused_bits;

    assign wb_stall = 1'b0;
    assign wb_err   = 1'b0;

    assign accept = wb_cyc & wb_stb;
    assign wr     = accept & wb_we;
    assign word   = wb_adr[4:2];
    assign bmask  = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};

    assign ctrl_val = 32'({presc, 7'd0, en});
    assign ctrl_new = (ctrl_val & ~bmask) | (wb_dat_i & bmask);

    assign tick      = en && (presc_cnt == presc);
    assign mtime_inc = mtime + {63'd0, tick};

    // Bus write overlays the post-increment value, so unwritten bytes still advance.
    always_comb begin
        mtime_next = mtime_inc;
        cmp_next   = mtimecmp;
        if (wr) begin
            case (word)
                REG_MTIME_LO: mtime_next[31:0]  = (mtime_inc[31:0] & ~bmask) | (wb_dat_i & bmask);
                REG_MTIME_HI: mtime_next[63:32] = (mtime_inc[63:32] & ~bmask) | (wb_dat_i & bmask);
                REG_CMP_LO:   cmp_next[31:0]    = (mtimecmp[31:0] & ~bmask) | (wb_dat_i & bmask);
                REG_CMP_HI:   cmp_next[63:32]   = (mtimecmp[63:32] & ~bmask) | (wb_dat_i & bmask);
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (word)
            REG_MTIME_LO: rdata = mtime[31:0];
            REG_MTIME_HI: rdata = mtime[63:32];
            REG_CMP_LO:   rdata = mtimecmp[31:0];
            REG_CMP_HI:   rdata = mtimecmp[63:32];
            REG_CTRL:     rdata = ctrl_val;
            default:      rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime     <= 64'd0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            en        <= 1'b0;
            presc     <= '0;
            presc_cnt <= '0;
            wb_ack    <= 1'b0;
            wb_dat_o  <= 32'd0;
            irq_timer <= 1'b0;
        end else begin
            mtime    <= mtime_next;
            mtimecmp <= cmp_next;
            if (wr && word == REG_CTRL) begin
                en        <= ctrl_new[0];
                presc     <= ctrl_new[PRESC_W+7:8];
                presc_cnt <= '0;
            end else if (en) begin
                presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
            end
            wb_ack    <= accept;
            wb_dat_o  <= (accept && !wb_we) ? rdata : 32'd0;
            irq_timer <= (mtime >= mtimecmp);
        end
    end

    assign unused_bits = ^{wb_adr, ctrl_new};

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: expected mtime is derived from elapsed clock
// edges and the prescale period rather than from a cycle-level copy of the design.
module tb_wb_timer;
    localparam logic [4:0] A_LO    = 5'h00;
    localparam logic [4:0] A_HI    = 5'h04;
    localparam logic [4:0] A_CMPLO = 5'h08;
    localparam logic [4:0] A_CMPHI = 5'h0C;
    localparam logic [4:0] A_CTRL  = 5'h10;
    localparam logic [4:0] A_GAP   = 5'h14;
    localparam logic [4:0] A_UNMAP = 5'h1C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_adr = 5'd0;
    logic [3:0]  wb_sel = 4'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        wb_stall;
    logic        wb_err;
    logic        irq_timer;

    int edge_cnt = 0;
    int vectors = 0;
    int miscompares = 0;

    wb_timer #(.ADDR_W(5), .PRESC_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_err(wb_err), .irq_timer(irq_timer)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Number of ticks on edges in (from_e, to_e] for a period of p+1 clocks, counting from a CTRL write at from_e.
    function automatic logic [63:0] ticks(input int from_e, input int to_e, input int p);
        return 64'((to_e - from_e) / (p + 1));
    endfunction

    // Called at a negedge; accepted on the next posedge, result sampled on the following negedge.
    task automatic bus(input logic we, input logic [4:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, output logic ack, output logic [31:0] rd,
                       output int acc);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
        acc = edge_cnt + 1;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        ack = wb_ack;
        rd  = wb_dat_o;
    endtask

    task automatic wr(input logic [4:0] adr, input logic [31:0] dat, output int acc);
        logic a;
        logic [31:0] d;
        bus(1'b1, adr, 4'hF, dat, a, d, acc);
    endtask

    task automatic rd(input logic [4:0] adr, output logic [31:0] dat);
        logic a;
        int e;
        bus(1'b0, adr, 4'hF, 32'd0, a, dat, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic a;
        logic [31:0] d;
        int e;
        logic [4:0]  adrs[5];
        logic [31:0] expv[5];
        adrs = '{A_LO, A_HI, A_CMPLO, A_CMPHI, A_CTRL};
        expv = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        vectors++;
        if (wb_ack !== 1'b0 || wb_dat_o !== 32'd0 || irq_timer !== 1'b0 || wb_stall !== 1'b0 || wb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ack=%b dat=%h irq=%b stall=%b err=%b, expected all 0",
                     wb_ack, wb_dat_o, irq_timer, wb_stall, wb_err);
        end
        for (int i = 0; i < 5; i++) begin
            bus(1'b0, adrs[i], 4'hF, 32'd0, a, d, e);
            vectors++;
            if (a !== 1'b1 || d !== expv[i]) begin
                miscompares++;
                $display("FAIL reset_read adr=%h: ack=%b data=%h, expected ack=1 data=%h", adrs[i], a, d, expv[i]);
            end
            idle(1);
            vectors++;
            if (wb_ack !== 1'b0 || wb_dat_o !== 32'd0) begin
                miscompares++;
                $display("FAIL ack_single_cycle adr=%h: ack=%b data=%h, expected 0/0", adrs[i], wb_ack, wb_dat_o);
            end
        end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        logic [63:0] expv;
        int e0, e, e2;
        logic a;
        wr(A_CTRL, 32'h0000_0301, e0);
        idle(40);
        bus(1'b0, A_CTRL, 4'hF, 32'd0, a, d, e);
        vectors++;
        if (a !== 1'b1 || d !== 32'h301) begin
            miscompares++;
            $display("FAIL ctrl_readback: ack=%b data=%h, expected 1/00000301", a, d);
        end
        bus(1'b0, A_LO, 4'hF, 32'd0, a, d, e2);
        expv = ticks(e0, e2 - 1, 3);
        vectors++;
        if (d !== expv[31:0]) begin
            miscompares++;
            $display("FAIL presc3_mtime: got %0d, expected %0d", d, expv[31:0]);
        end
    endtask

    task automatic test_carry();
        logic [63:0] bases[2];
        int gaps[2];
        logic [63:0] expv;
        logic [31:0] lo, hi;
        int e, e0, e1;
        bases = '{64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
        gaps  = '{1, 0};
        for (int i = 0; i < 2; i++) begin
            wr(A_CTRL, 32'd0, e);
            wr(A_LO, bases[i][31:0], e);
            wr(A_HI, bases[i][63:32], e);
            wr(A_CTRL, 32'd1, e0);
            idle(gaps[i]);
            wr(A_CTRL, 32'd0, e1);
            expv = bases[i] + ticks(e0, e1, 0);
            rd(A_HI, hi);
            rd(A_LO, lo);
            vectors++;
            if ({hi, lo} !== expv) begin
                miscompares++;
                $display("FAIL carry_wrap case %0d: got %h, expected %h", i, {hi, lo}, expv);
            end
        end
    endtask

    task automatic test_irq();
        int e, e0, ew, k;
        logic expv;
        wr(A_CTRL, 32'd0, e);
        wr(A_CMPLO, 32'd100, e);
        wr(A_CMPHI, 32'd0, e);
        wr(A_LO, 32'd0, e);
        wr(A_HI, 32'd0, e);
        wr(A_CTRL, 32'd1, e0);
        for (int i = 0; i < 115; i++) begin
            idle(1);
            k = edge_cnt;
            expv = (ticks(e0, k - 1, 0) >= 64'd100);
            vectors++;
            if (irq_timer !== expv) begin
                miscompares++;
                $display("FAIL irq_level edge+%0d: irq=%b, expected %b", k - e0, irq_timer, expv);
            end
        end
        wr(A_CMPHI, 32'd1, ew);
        vectors++;
        if (irq_timer !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_lag_on_raise: irq=%b, expected 1", irq_timer);
        end
        idle(1);
        vectors++;
        if (irq_timer !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: irq=%b, expected 0", irq_timer);
        end
        wr(A_CTRL, 32'd0, e);
    endtask

    task automatic test_collision();
        logic [63:0] base, expv;
        logic [31:0] dat, lo, hi, d;
        logic a;
        int e, e0, ew, ed;
        for (int i = 0; i < 3; i++) begin
            base = {$urandom, $urandom};
            if (i == 0) base[7:0] = 8'hFF;
            dat = (i == 0) ? 32'h0000_00AA : $urandom;
            wr(A_CTRL, 32'd0, e);
            wr(A_LO, base[31:0], e);
            wr(A_HI, base[63:32], e);
            wr(A_CTRL, 32'd1, e0);
            idle($urandom_range(1, 4));
            bus(1'b1, A_LO, 4'b0001, dat, a, d, ew);
            wr(A_CTRL, 32'd0, ed);
            expv = base + ticks(e0, ew, 0);
            expv[7:0] = dat[7:0];
            expv = expv + ticks(ew, ed, 0);
            rd(A_LO, lo);
            rd(A_HI, hi);
            vectors++;
            if ({hi, lo} !== expv) begin
                miscompares++;
                $display("FAIL tick_write_collision %0d: got %h, expected %h", i, {hi, lo}, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r[4];
        logic [4:0]  adrs[6];
        logic [31:0] expv[6];
        logic a;
        logic [31:0] d;
        int e;
        for (int i = 0; i < 4; i++) r[i] = $urandom;
        wr(A_LO, r[0], e);
        wr(A_HI, r[1], e);
        wr(A_CMPLO, r[2], e);
        wr(A_CMPHI, r[3], e);
        wr(A_GAP, 32'hFFFF_FFFF, e);
        adrs = '{A_LO, A_HI, A_CMPLO, A_CMPHI, A_UNMAP, A_CTRL};
        expv = '{r[0], r[1], r[2], r[3], 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            bus(1'b0, adrs[i], 4'hF, 32'd0, a, d, e);
            vectors++;
            if (a !== 1'b1 || d !== expv[i]) begin
                miscompares++;
                $display("FAIL b2b_read adr=%h: ack=%b data=%h, expected ack=1 data=%h", adrs[i], a, d, expv[i]);
            end
        end
    endtask

    task automatic test_random_prescale();
        logic [63:0] base, expv;
        logic [31:0] lo, hi;
        int p, e, e0, e1;
        for (int i = 0; i < 6; i++) begin
            p = int'($urandom_range(0, 5));
            base = {$urandom, $urandom};
            wr(A_CTRL, 32'd0, e);
            wr(A_LO, base[31:0], e);
            wr(A_HI, base[63:32], e);
            wr(A_CTRL, (32'(p) << 8) | 32'd1, e0);
            idle($urandom_range(5, 60));
            wr(A_CTRL, 32'(p) << 8, e1);
            expv = base + ticks(e0, e1, p);
            rd(A_LO, lo);
            rd(A_HI, hi);
            vectors++;
            if ({hi, lo} !== expv) begin
                miscompares++;
                $display("FAIL random_presc p=%0d run=%0d: got %h, expected %h", p, e1 - e0, {hi, lo}, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = A_CMPLO; wb_sel = 4'hF;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        vectors++;
        if (wb_ack !== 1'b0 || wb_dat_o !== 32'd0 || irq_timer !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_transfer: ack=%b data=%h irq=%b, expected 0/0/0", wb_ack, wb_dat_o, irq_timer);
        end
        rst_n = 1'b1;
        rd(A_CMPLO, d);
        vectors++;
        if (d !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL reset_mid_cmp: got %h, expected ffffffff", d);
        end
        rd(A_LO, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_mtime: got %h, expected 0", d);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_prescale();
        test_carry();
        test_irq();
        test_collision();
        test_back_to_back();
        test_random_prescale();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
